// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 (even parity) frames
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_stb,
    input  logic [7:0]          tx_byte,
    input  logic                tx_hold,
    output logic                tx_full,
    output logic                tx_busy,
    output logic [DEPTH_LOG2:0] tx_level,
    output logic                tx_ovf,
    output logic                uart_tx
);
    localparam int BIT_CYC = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LW      = DEPTH_LOG2 + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr, r_rd;
    logic [LW-1:0]         r_level, w_level_nxt;
    logic                  r_full, r_busy, r_ovf, r_tx;
    logic [CW-1:0]         r_baud;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  w_bit_end, w_ready, w_pop, w_push, w_tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic                  r_par;
`endif

    assign w_bit_end   = r_baud == CW'(BIT_CYC - 1);
    assign w_ready     = r_level != '0 && !tx_hold;
    assign w_push      = tx_stb && (!r_full || w_pop);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    assign tx_full  = r_full;
    assign tx_busy  = r_busy;
    assign tx_level = r_level;
    assign tx_ovf   = r_ovf;
    assign uart_tx  = r_tx;

    // Frame sequencing: next state, FIFO pop and the next registered line level
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = r_tx;
        case (r_state)
            IDLE: if (w_ready) begin
                w_state_nxt = START;
                w_pop       = 1'b1;
                w_tx_nxt    = 1'b0;
            end
            START: if (w_bit_end) begin
                w_state_nxt = DATA;
                w_tx_nxt    = r_shift[0];
            end
            DATA: if (w_bit_end) begin
                if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = PARITY;
                    w_tx_nxt    = r_par;
`else
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
`endif
                end else
                    w_tx_nxt = r_shift[1];
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_bit_end) begin
                w_state_nxt = STOP;
                w_tx_nxt    = 1'b1;
            end
`endif
            STOP: if (w_bit_end) begin
                if (w_ready) begin
                    w_state_nxt = START;
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                end else
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Bit timing, shift register and registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_tx   <= w_tx_nxt;
            r_baud <= (r_state == IDLE || w_bit_end) ? '0 : r_baud + CW'(1);
            if (w_pop)
                r_shift <= r_mem[r_rd];
            else if (r_state == DATA && w_bit_end)
                r_shift <= r_shift >> 1;
            if (w_pop)
                r_bit <= '0;
            else if (r_state == DATA && w_bit_end)
                r_bit <= r_bit + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte being loaded, captured with it
    always_ff @(posedge clk) begin
        if (rst)        r_par <= 1'b0;
        else if (w_pop) r_par <= ^r_mem[r_rd];
    end
`endif

    // FIFO pointers and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd <= r_rd + DEPTH_LOG2'(1);
            r_level <= w_level_nxt;
            r_full  <= w_level_nxt == LW'(DEPTH);
            r_busy  <= w_level_nxt != '0 || w_state_nxt != IDLE;
            r_ovf   <= tx_stb && !w_push;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wr] <= tx_byte;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a frame-level queue model
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 80000;
    localparam int BIT_CYC  = 13;
    localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = NB * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst, tx_stb, tx_hold;
    logic [7:0] tx_byte;
    logic       tx_full, tx_busy, tx_ovf, uart_tx;
    logic [4:0] tx_level;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .tx_stb(tx_stb), .tx_byte(tx_byte), .tx_hold(tx_hold),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_level(tx_level), .tx_ovf(tx_ovf), .uart_tx(uart_tx)
    );

    logic [7:0]  q[$];
    bit          act;
    longint      k, fst;
    logic [10:0] fr;
    logic        e_tx, e_busy, e_full, e_ovf;
    int          e_level;
    int          nvec, nerr;

    logic [8:0] w_got;
    assign w_got = {uart_tx, tx_busy, tx_full, tx_ovf, tx_level};

    function automatic logic [8:0] expv();
        return {e_tx, e_busy, e_full, e_ovf, 5'(e_level)};
    endfunction

    // Frame-level model: a queue of bytes plus the edge at which the current frame started
    task automatic model(input logic stb, input logic [7:0] b, input logic hold, input logic rs);
        bit done, pop, push;
        k++;
        if (rs) begin
            q.delete();
            act   = 1'b0;
            e_ovf = 1'b0;
        end else begin
            done  = !act || (k - fst == FRAME);
            pop   = done && q.size() > 0 && !hold;
            push  = stb && (q.size() < DEPTH || pop);
            e_ovf = stb && !push;
            if (pop) begin
                fr = {2'b11, q[0], 1'b0};
                if (PAR) fr[9] = ^q[0];
                void'(q.pop_front());
                fst = k;
                act = 1'b1;
            end else if (done)
                act = 1'b0;
            if (push) q.push_back(b);
        end
        e_level = q.size();
        e_full  = e_level == DEPTH;
        e_busy  = e_level != 0 || act;
        e_tx    = act ? fr[int'((k - fst) / BIT_CYC)] : 1'b1;
    endtask

    task automatic step(input logic stb, input logic [7:0] b, input logic hold, input logic rs);
        tx_stb  = stb;
        tx_byte = b;
        tx_hold = hold;
        rst     = rs;
        @(posedge clk);
        model(stb, b, hold, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b1, 8'h12, 1'b0, 1'b1);
        nvec++;
        if (w_got !== 9'b1_0_0_0_00000) begin
            nerr++;
            $display("FAIL reset_state: got %b want %b", w_got, 9'b1_0_0_0_00000);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        nvec++;
        if (w_got !== expv()) begin
            nerr++;
            $display("FAIL reset_idle: got %b want %b", w_got, expv());
        end
    endtask

    task automatic test_single();
        int low_at, busy_n;
        logic [7:0] got_b;
        low_at = -1;
        busy_n = 0;
        got_b  = 8'h00;
        step(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 1; i <= FRAME + 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL single cyc %0d: got %b want %b", k, w_got, expv());
            end
            if (uart_tx === 1'b0 && low_at < 0) low_at = i;
            if (tx_busy === 1'b1) busy_n++;
            if (low_at > 0 && i - low_at >= BIT_CYC && i - low_at < 9 * BIT_CYC && (i - low_at) % BIT_CYC == BIT_CYC / 2)
                got_b[(i - low_at) / BIT_CYC - 1] = uart_tx;
        end
        nvec++;
        if (low_at !== 1) begin
            nerr++;
            $display("FAIL single_latency: start bit after %0d cycles, want 1", low_at);
        end
        nvec++;
        if (busy_n !== FRAME) begin
            nerr++;
            $display("FAIL single_busy: busy %0d cycles, want %0d", busy_n, FRAME);
        end
        nvec++;
        if (got_b !== 8'h55) begin
            nerr++;
            $display("FAIL single_data: got %h want 55", got_b);
        end
    endtask

    task automatic test_back_to_back();
        int peak, busy_n;
        peak   = 0;
        busy_n = 0;
        for (int i = 0; i < 3 * FRAME + 6; i++) begin
            step(i < 3, 8'(8'h41 + i), 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL b2b cyc %0d: got %b want %b", k, w_got, expv());
            end
            if (int'(tx_level) > peak) peak = int'(tx_level);
            if (tx_busy === 1'b1) busy_n++;
        end
        nvec++;
        if (peak !== 2) begin
            nerr++;
            $display("FAIL b2b_peak: got %0d want 2", peak);
        end
        nvec++;
        if (busy_n !== 3 * FRAME + 1) begin
            nerr++;
            $display("FAIL b2b_busy: got %0d want %0d", busy_n, 3 * FRAME + 1);
        end
    endtask

    task automatic test_overflow();
        int ph, nb;
        logic [7:0] sh;
        sh = 8'h00;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL ovf_fill cyc %0d: got %b want %b", k, w_got, expv());
            end
        end
        nvec++;
        if (tx_ovf !== 1'b1 || tx_level !== 5'd16 || tx_full !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_drop: ovf %b level %0d full %b, want 1 16 1", tx_ovf, tx_level, tx_full);
        end
        ph = -1;
        nb = 0;
        for (int i = 0; i < 16 * FRAME + 5; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL ovf_drain cyc %0d: got %b want %b", k, w_got, expv());
            end
            if (ph < 0 && uart_tx === 1'b0) ph = 0;
            else if (ph >= 0) ph++;
            if (ph >= BIT_CYC && ph < 9 * BIT_CYC && ph % BIT_CYC == BIT_CYC / 2)
                sh[ph / BIT_CYC - 1] = uart_tx;
            if (ph == FRAME - 1) begin
                nvec++;
                if (sh !== 8'(nb)) begin
                    nerr++;
                    $display("FAIL ovf_order: frame %0d got %h want %h", nb, sh, 8'(nb));
                end
                nb++;
                ph = -1;
            end
        end
        nvec++;
        if (nb !== 16) begin
            nerr++;
            $display("FAIL ovf_count: got %0d frames want 16", nb);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hD0, 1'b0, 1'b0);
        nvec++;
        if (tx_full !== 1'b1 || tx_level !== 5'd16) begin
            nerr++;
            $display("FAIL fullpop_pre: full %b level %0d, want 1 16", tx_full, tx_level);
        end
        for (int g = 0; g < FRAME && k + 1 - fst != FRAME; g++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL fullpop_wait cyc %0d: got %b want %b", k, w_got, expv());
            end
        end
        step(1'b1, 8'hD1, 1'b0, 1'b0);
        nvec++;
        if (tx_ovf !== 1'b0 || tx_level !== 5'd16 || tx_full !== 1'b1) begin
            nerr++;
            $display("FAIL fullpop: ovf %b level %0d full %b, want 0 16 1", tx_ovf, tx_level, tx_full);
        end
        step(1'b1, 8'hD2, 1'b0, 1'b0);
        nvec++;
        if (tx_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL fullpop_drop: ovf %b want 1", tx_ovf);
        end
        for (int i = 0; i < 17 * FRAME + 5; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL fullpop_drain cyc %0d: got %b want %b", k, w_got, expv());
            end
        end
    endtask

    task automatic test_reset_midframe();
        int lows;
        lows = 0;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int g = 0; g < FRAME && (k - fst) / BIT_CYC != 4; g++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL rstmid_run cyc %0d: got %b want %b", k, w_got, expv());
            end
        end
        nvec++;
        if (tx_level !== 5'd4) begin
            nerr++;
            $display("FAIL rstmid_pre: level %0d want 4", tx_level);
        end
        step(1'b1, 8'h99, 1'b0, 1'b1);
        nvec++;
        if (uart_tx !== 1'b1 || tx_level !== 5'd0 || tx_busy !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid: tx %b level %0d busy %b, want 1 0 0", uart_tx, tx_level, tx_busy);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL rstmid_after cyc %0d: got %b want %b", k, w_got, expv());
            end
            if (uart_tx === 1'b0) lows++;
        end
        nvec++;
        if (lows !== 0) begin
            nerr++;
            $display("FAIL rstmid_quiet: %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_parity();
        int ph, nf, busy_n;
        logic [1:0] p9;
        ph     = -1;
        nf     = 0;
        busy_n = 0;
        p9     = 2'bxx;
        for (int i = 0; i < 2 * FRAME + 6; i++) begin
            step(i < 2, i == 0 ? 8'h07 : 8'h03, 1'b0, 1'b0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL parity cyc %0d: got %b want %b", k, w_got, expv());
            end
            if (tx_busy === 1'b1) busy_n++;
            if (ph < 0 && uart_tx === 1'b0) ph = 0;
            else if (ph >= 0) ph++;
            if (ph == 9 * BIT_CYC + BIT_CYC / 2 && nf < 2) p9[nf] = uart_tx;
            if (ph == FRAME - 1) begin
                nf++;
                ph = -1;
            end
        end
        nvec++;
        if (p9 !== {!PAR, 1'b1}) begin
            nerr++;
            $display("FAIL parity_bit: got %b want %b", p9, {!PAR, 1'b1});
        end
        nvec++;
        if (busy_n !== 2 * FRAME + 1) begin
            nerr++;
            $display("FAIL parity_len: busy %0d want %0d", busy_n, 2 * FRAME + 1);
        end
    endtask

    task automatic test_random();
        int stb_pct, hold_pct;
        logic hold;
        hold     = 1'b0;
        stb_pct  = 0;
        hold_pct = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) begin
                stb_pct  = $urandom_range(0, 3) == 0 ? 60 : int'($urandom_range(1, 8));
                hold_pct = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 99) < hold_pct) hold = !hold;
            step($urandom_range(0, 99) < stb_pct, 8'($urandom), hold, $urandom_range(0, 1999) == 0);
            nvec++;
            if (w_got !== expv()) begin
                nerr++;
                $display("FAIL random cyc %0d: got %b want %b", k, w_got, expv());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nvec    = 0;
        nerr    = 0;
        k       = 0;
        fst     = 0;
        act     = 1'b0;
        fr      = 11'h7FF;
        rst     = 1'b1;
        tx_stb  = 1'b0;
        tx_byte = 8'h00;
        tx_hold = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
